register_file_wb: RTL and testbench

REGISTER_FILE_WB -- requirements
Module: register_file_wb

---
 rtl/register_file_wb.sv | 138 +++++++++++++
 tb/tb_register_file_wb.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/register_file_wb.sv
// 32-entry register file with write-through bypass and per-register pending-write
// scoreboard counters that drive issue back-pressure and read-hazard detection.
module register_file_wb #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            readAddr1,
    input  logic [4:0]            readAddr2,
    input  logic                  readUse1,
    input  logic                  readUse2,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2,
    input  logic                  regWrite,
    input  logic [4:0]            writeAddr,
    input  logic [DATA_WIDTH-1:0] dataBack,
    input  logic                  issueValid,
    input  logic [4:0]            issueRd,
    output logic                  issueReady,
    output logic                  hazard,
    output logic                  wbOrphan
);

    localparam logic [CNT_WIDTH-1:0]  PEND_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  PEND_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  PEND_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] r_regs [32];
    logic [CNT_WIDTH-1:0]  r_pend [32];
    logic                  r_wb_orphan;

    logic [CNT_WIDTH-1:0]  w_pend_next [32];
    logic                  w_wb_valid;
    logic                  w_retire;
    logic                  w_accept;
    logic                  w_orphan;
    logic                  w_issue_ready;
    logic                  w_haz1;
    logic                  w_haz2;
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;

    // Writeback qualification, issue acceptance and back-pressure.
    always_comb begin
        w_wb_valid = regWrite && (writeAddr != 5'd0);
        w_retire   = w_wb_valid && (r_pend[writeAddr] != PEND_ZERO);
        w_orphan   = w_wb_valid && (r_pend[writeAddr] == PEND_ZERO);
        // A same-cycle retire frees a slot, so a full counter can still accept.
        if ((issueRd != 5'd0) && (r_pend[issueRd] == PEND_MAX) &&
            !(w_retire && (writeAddr == issueRd))) begin
            w_issue_ready = 1'b0;
        end else begin
            w_issue_ready = 1'b1;
        end
        w_accept = issueValid && w_issue_ready && (issueRd != 5'd0);
    end

    // Next value of every pending counter; x0 never tracks anything.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            if (i == 0) begin
                w_pend_next[i] = PEND_ZERO;
            end else if (w_accept && (issueRd == 5'(i)) &&
                         !(w_retire && (writeAddr == 5'(i)))) begin
                if (r_pend[i] != PEND_MAX) begin
                    w_pend_next[i] = r_pend[i] + PEND_ONE;
                end else begin
                    w_pend_next[i] = r_pend[i];
                end
            end else if (w_retire && (writeAddr == 5'(i)) &&
                         !(w_accept && (issueRd == 5'(i)))) begin
                w_pend_next[i] = r_pend[i] - PEND_ONE;
            end else begin
                w_pend_next[i] = r_pend[i];
            end
        end
    end

    // Read ports with write-through bypass and x0 forced to zero.
    always_comb begin
        if (readAddr1 == 5'd0) begin
            w_rd1 = DATA_ZERO;
        end else if (w_wb_valid && (writeAddr == readAddr1)) begin
            w_rd1 = dataBack;
        end else begin
            w_rd1 = r_regs[readAddr1];
        end
        if (readAddr2 == 5'd0) begin
            w_rd2 = DATA_ZERO;
        end else if (w_wb_valid && (writeAddr == readAddr2)) begin
            w_rd2 = dataBack;
        end else begin
            w_rd2 = r_regs[readAddr2];
        end
    end

    // Source hazards; the last outstanding write arriving now is covered by bypass.
    always_comb begin
        if (readUse1 && (readAddr1 != 5'd0) && (r_pend[readAddr1] != PEND_ZERO) &&
            !((r_pend[readAddr1] == PEND_ONE) && w_retire && (writeAddr == readAddr1))) begin
            w_haz1 = 1'b1;
        end else begin
            w_haz1 = 1'b0;
        end
        if (readUse2 && (readAddr2 != 5'd0) && (r_pend[readAddr2] != PEND_ZERO) &&
            !((r_pend[readAddr2] == PEND_ONE) && w_retire && (writeAddr == readAddr2))) begin
            w_haz2 = 1'b1;
        end else begin
            w_haz2 = 1'b0;
        end
    end

    // Storage, scoreboard and orphan flag state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= DATA_ZERO;
                r_pend[i] <= PEND_ZERO;
            end
            r_wb_orphan <= 1'b0;
        end else begin
            if (w_wb_valid) begin
                r_regs[writeAddr] <= dataBack;
            end
            r_pend      <= w_pend_next;
            r_wb_orphan <= w_orphan;
        end
    end

    assign readData1  = w_rd1;
    assign readData2  = w_rd2;
    assign hazard     = w_haz1 || w_haz2;
    assign issueReady = w_issue_ready;
    assign wbOrphan   = r_wb_orphan;

endmodule

// File: tb/tb_register_file_wb.sv
// Directed, table-driven bench for register_file_wb with hand-computed expectations.
module tb_register_file_wb;

    logic        clk;
    logic        reset;
    logic [4:0]  readAddr1, readAddr2;
    logic        readUse1, readUse2;
    logic [31:0] readData1, readData2;
    logic        regWrite;
    logic [4:0]  writeAddr;
    logic [31:0] dataBack;
    logic        issueValid;
    logic [4:0]  issueRd;
    logic        issueReady, hazard, wbOrphan;

    int checks = 0;
    int errors = 0;

    register_file_wb #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut (
        .clk(clk), .reset(reset),
        .readAddr1(readAddr1), .readAddr2(readAddr2),
        .readUse1(readUse1), .readUse2(readUse2),
        .readData1(readData1), .readData2(readData2),
        .regWrite(regWrite), .writeAddr(writeAddr), .dataBack(dataBack),
        .issueValid(issueValid), .issueRd(issueRd),
        .issueReady(issueReady), .hazard(hazard), .wbOrphan(wbOrphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic        u1;
        logic [4:0]  ra2;
        logic        u2;
        logic        iv;
        logic [4:0]  ird;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_haz;
        logic        e_rdy;
        logic        e_orph;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [4:0] ra1, input logic u1,
                                input logic [4:0] ra2, input logic u2, input logic iv,
                                input logic [4:0] ird, input logic [31:0] e_rd1,
                                input logic [31:0] e_rd2, input logic e_haz,
                                input logic e_rdy, input logic e_orph);
        vec_t v;
        v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.ra1 = ra1; v.u1 = u1;
        v.ra2 = ra2; v.u2 = u2; v.iv = iv; v.ird = ird; v.e_rd1 = e_rd1;
        v.e_rd2 = e_rd2; v.e_haz = e_haz; v.e_rdy = e_rdy; v.e_orph = e_orph;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; regWrite = v.we; writeAddr = v.wa; dataBack = v.wd;
        readAddr1 = v.ra1; readUse1 = v.u1; readAddr2 = v.ra2; readUse2 = v.u2;
        issueValid = v.iv; issueRd = v.ird;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //                rst we  wa     wd            ra1    u1    ra2    u2    iv    ird    rd1           rd2           haz   rdy   orph
        // reset state
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd31,1'b1,5'd17,1'b1,1'b0,5'd5, 32'h0,        32'h0,        1'b0,1'b1,1'b0));
        // write then read: bypass, storage, orphan pulse
        vecs.push_back(mk(1'b0,1'b1,5'd5, 32'hDEADBEEF, 5'd5, 1'b0,5'd0, 1'b0,1'b0,5'd0, 32'hDEADBEEF, 32'h0,        1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd5, 1'b0,5'd0, 1'b0,1'b0,5'd0, 32'hDEADBEEF, 32'h0,        1'b0,1'b1,1'b1));
        // x0 write discarded, no orphan
        vecs.push_back(mk(1'b0,1'b1,5'd0, 32'hFFFFFFFF, 5'd0, 1'b1,5'd5, 1'b0,1'b0,5'd0, 32'h0,        32'hDEADBEEF, 1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd0, 1'b1,5'd0, 1'b0,1'b0,5'd0, 32'h0,        32'h0,        1'b0,1'b1,1'b0));
        // hazard on x7 via port 2
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd0, 1'b0,5'd0, 1'b0,1'b1,5'd7, 32'h0,        32'h0,        1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd0, 1'b0,5'd7, 1'b1,1'b0,5'd0, 32'h0,        32'h0,        1'b1,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd0, 1'b0,5'd7, 1'b0,1'b0,5'd0, 32'h0,        32'h0,        1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b1,5'd7, 32'h12345678, 5'd0, 1'b0,5'd7, 1'b1,1'b0,5'd0, 32'h0,        32'h12345678, 1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd0, 1'b0,5'd7, 1'b1,1'b0,5'd0, 32'h0,        32'h12345678, 1'b0,1'b1,1'b0));
        // hazard on x7 via port 1
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd7, 1'b1,5'd0, 1'b0,1'b1,5'd7, 32'h12345678, 32'h0,        1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd7, 1'b1,5'd0, 1'b0,1'b0,5'd0, 32'h12345678, 32'h0,        1'b1,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b1,5'd7, 32'hA5A5A5A5, 5'd7, 1'b1,5'd0, 1'b0,1'b0,5'd0, 32'hA5A5A5A5, 32'h0,        1'b0,1'b1,1'b0));
        // saturation on x3
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd0, 1'b0,5'd0, 1'b0,1'b1,5'd3, 32'h0,        32'h0,        1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd0, 1'b0,5'd0, 1'b0,1'b1,5'd3, 32'h0,        32'h0,        1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd0, 1'b0,5'd0, 1'b0,1'b1,5'd3, 32'h0,        32'h0,        1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd0, 1'b0,5'd0, 1'b0,1'b0,5'd3, 32'h0,        32'h0,        1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd0, 1'b0,5'd0, 1'b0,1'b0,5'd4, 32'h0,        32'h0,        1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd0, 1'b0,5'd0, 1'b0,1'b1,5'd3, 32'h0,        32'h0,        1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,5'd3, 32'h33,       5'd3, 1'b1,5'd0, 1'b0,1'b1,5'd3, 32'h33,       32'h0,        1'b1,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd0, 1'b0,5'd0, 1'b0,1'b0,5'd3, 32'h0,        32'h0,        1'b0,1'b0,1'b0));
        // drain x3: 3 -> 2 -> 1 -> 0, hazard lifts only on the last retire
        vecs.push_back(mk(1'b0,1'b1,5'd3, 32'h31,       5'd3, 1'b1,5'd0, 1'b0,1'b0,5'd0, 32'h31,       32'h0,        1'b1,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b1,5'd3, 32'h32,       5'd3, 1'b1,5'd0, 1'b0,1'b0,5'd0, 32'h32,       32'h0,        1'b1,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b1,5'd3, 32'h34,       5'd3, 1'b1,5'd0, 1'b0,1'b0,5'd0, 32'h34,       32'h0,        1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd3, 1'b1,5'd0, 1'b0,1'b0,5'd3, 32'h34,       32'h0,        1'b0,1'b1,1'b0));
        // orphan writeback to x9
        vecs.push_back(mk(1'b0,1'b1,5'd9, 32'h99,       5'd9, 1'b0,5'd0, 1'b0,1'b0,5'd0, 32'h99,       32'h0,        1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd9, 1'b0,5'd0, 1'b0,1'b0,5'd0, 32'h99,       32'h0,        1'b0,1'b1,1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd9, 1'b0,5'd0, 1'b0,1'b0,5'd0, 32'h99,       32'h0,        1'b0,1'b1,1'b0));
        // reset mid-flight with pend[4]=2 and reg[4]=0x55
        vecs.push_back(mk(1'b0,1'b1,5'd4, 32'h55,       5'd0, 1'b0,5'd0, 1'b0,1'b0,5'd0, 32'h0,        32'h0,        1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd0, 1'b0,5'd0, 1'b0,1'b1,5'd4, 32'h0,        32'h0,        1'b0,1'b1,1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd4, 1'b1,5'd0, 1'b0,1'b1,5'd4, 32'h55,       32'h0,        1'b1,1'b1,1'b0));
        vecs.push_back(mk(1'b1,1'b1,5'd6, 32'h66,       5'd4, 1'b1,5'd6, 1'b0,1'b1,5'd6, 32'h55,       32'h66,       1'b1,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd4, 1'b1,5'd6, 1'b1,1'b0,5'd6, 32'h0,        32'h0,        1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b1,5'd4, 32'h44,       5'd0, 1'b0,5'd0, 1'b0,1'b0,5'd0, 32'h0,        32'h0,        1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd4, 1'b0,5'd0, 1'b0,1'b0,5'd0, 32'h44,       32'h0,        1'b0,1'b1,1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,        5'd4, 1'b0,5'd0, 1'b0,1'b0,5'd0, 32'h44,       32'h0,        1'b0,1'b1,1'b0));

        reset = 1'b1; regWrite = 1'b0; writeAddr = 5'd0; dataBack = 32'h0;
        readAddr1 = 5'd0; readAddr2 = 5'd0; readUse1 = 1'b0; readUse2 = 1'b0;
        issueValid = 1'b0; issueRd = 5'd0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("v%0d_rd1", i), readData1, vecs[i].e_rd1);
            check($sformatf("v%0d_rd2", i), readData2, vecs[i].e_rd2);
            check($sformatf("v%0d_hazard", i), {31'd0, hazard}, {31'd0, vecs[i].e_haz});
            check($sformatf("v%0d_ready", i), {31'd0, issueReady}, {31'd0, vecs[i].e_rdy});
            check($sformatf("v%0d_orphan", i), {31'd0, wbOrphan}, {31'd0, vecs[i].e_orph});
            @(posedge clk);
            #1;
        end

        // Fill every register with a distinct pattern, then read back from storage.
        regWrite = 1'b1; reset = 1'b0; issueValid = 1'b0; readUse1 = 1'b0; readUse2 = 1'b0;
        for (int r = 0; r < 32; r++) begin
            writeAddr = 5'(r);
            dataBack  = 32'hC0DE0000 | 32'(r * 17);
            @(posedge clk);
            #1;
        end
        regWrite = 1'b0;
        for (int r = 0; r < 32; r++) begin
            readAddr1 = 5'(r);
            readAddr2 = 5'(31 - r);
            @(negedge clk);
            check($sformatf("fill_rd1_x%0d", r), readData1,
                  (r == 0) ? 32'h0 : (32'hC0DE0000 | 32'(r * 17)));
            check($sformatf("fill_rd2_x%0d", 31 - r), readData2,
                  (r == 31) ? 32'h0 : (32'hC0DE0000 | 32'((31 - r) * 17)));
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
